// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for jk_mod_counter: count controls in,
// registered count, JK excitation and terminal/wrap flags out.
interface jk_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up, load, load_val,
      input  q, j_vec, k_vec, tc, wrap
   );

   modport slave (
      input  en, up, load, load_val,
      output q, j_vec, k_vec, tc, wrap
   );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK stages: the desired next count is
// turned into per-bit J/K drives, and each bit then updates with JK rules.
module jk_mod_counter #(
   parameter int WIDTH  = 4,
   parameter int MODULO = 10
) (
   input logic              CP,
   input logic              n_rst,
   jk_mod_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             tc;
   logic             wrap_r;

   // NOTE: every variable written in always_comb gets a default on entry so
   // that no path leaves it unassigned and no latch is inferred.
   always_comb begin
      nxt = q_r;
      if (bus.load) begin
         nxt = ({1'b0, bus.load_val} >= MOD_EXT) ? MAX_CNT : bus.load_val;
      end else if (bus.en) begin
         if (bus.up) nxt = (q_r == MAX_CNT) ? '0 : q_r + ONE;
         else        nxt = (q_r == '0) ? MAX_CNT : q_r - ONE;
      end
   end

   // Excitation only ever sets or clears a bit that must change.
   assign j  = ~q_r & nxt;
   assign k  = q_r & ~nxt;
   assign tc = bus.en & ~bus.load & (bus.up ? (q_r == MAX_CNT) : (q_r == '0));

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the pre-edge values, exactly like real flip-flops.
   always_ff @(posedge CP or negedge n_rst) begin
      if (!n_rst) begin
         q_r    <= '0;
         wrap_r <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
               2'b10:   q_r[i] <= 1'b1;
               2'b01:   q_r[i] <= 1'b0;
               2'b11:   q_r[i] <= ~q_r[i];
               default: q_r[i] <= q_r[i];
            endcase
         end
         wrap_r <= tc;
      end
   end

   assign bus.q     = q_r;
   assign bus.j_vec = j;
   assign bus.k_vec = k;
   assign bus.tc    = tc;
   assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed scenarios on a decade
// counter, then random stimulus on MODULO=10 and MODULO=16 against a model.
module tb_jk_mod_counter;

   logic CP;
   logic n_rst;
   int   total;
   int   bad;

   jk_mod_counter_if #(.WIDTH(4)) b10 ();
   jk_mod_counter_if #(.WIDTH(4)) b16 ();

   jk_mod_counter #(.WIDTH(4), .MODULO(10)) dut10 (.CP(CP), .n_rst(n_rst), .bus(b10));
   jk_mod_counter #(.WIDTH(4), .MODULO(16)) dut16 (.CP(CP), .n_rst(n_rst), .bus(b16));

   initial CP = 1'b0;
   always #5 CP = ~CP;

   // Reference next count, straight from the counting rules.
   function automatic int model_nxt(int m, int q, bit en, bit up, bit load, int lv);
      if (load) return (lv >= m) ? m - 1 : lv;
      if (en)   return up ? (q + 1) % m : (q + m - 1) % m;
      return q;
   endfunction

   function automatic bit model_tc(int m, int q, bit en, bit up, bit load);
      return en && !load && (up ? (q == m - 1) : (q == 0));
   endfunction

   function automatic logic [3:0] exc_j(int q, int n);
      logic [3:0] r = '0;
      for (int i = 0; i < 4; i++) if (((q >> i) & 1) == 0 && ((n >> i) & 1) == 1) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] exc_k(int q, int n);
      logic [3:0] r = '0;
      for (int i = 0; i < 4; i++) if (((q >> i) & 1) == 1 && ((n >> i) & 1) == 0) r[i] = 1'b1;
      return r;
   endfunction

   task automatic drive10(bit en, bit up, bit load, logic [3:0] lv);
      b10.en = en; b10.up = up; b10.load = load; b10.load_val = lv;
   endtask

   task automatic tick();
      @(posedge CP);
      #2;
   endtask

   task automatic test_reset();
      total++;
      if (b10.q !== 4'd0 || b10.wrap !== 1'b0) begin
         bad++; $display("FAIL reset_initial: q=%0d wrap=%b want q=0 wrap=0", b10.q, b10.wrap);
      end
      n_rst = 1'b1;
      drive10(1'b0, 1'b1, 1'b1, 4'd7);
      tick();
      drive10(1'b0, 1'b1, 1'b0, 4'd0);
      total++;
      if (b10.q !== 4'd7) begin bad++; $display("FAIL reset_preload: q=%0d want 7", b10.q); end
      n_rst = 1'b0;
      #1;
      total++;
      if (b10.q !== 4'd0 || b10.wrap !== 1'b0) begin
         bad++; $display("FAIL reset_async: q=%0d wrap=%b want q=0 wrap=0", b10.q, b10.wrap);
      end
      tick();
      n_rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (b10.q !== 4'd0 || b10.j_vec !== 4'd0 || b10.k_vec !== 4'd0) begin
            bad++; $display("FAIL reset_idle: q=%0d j=%b k=%b want 0/0000/0000", b10.q, b10.j_vec, b10.k_vec);
         end
      end
   endtask

   task automatic test_up_wrap();
      drive10(1'b1, 1'b1, 1'b0, 4'd0);
      for (int i = 1; i <= 9; i++) begin
         tick();
         total++;
         if (b10.q !== 4'(i) || b10.wrap !== 1'b0) begin
            bad++; $display("FAIL up_count: q=%0d wrap=%b want q=%0d wrap=0", b10.q, b10.wrap, i);
         end
      end
      total++;
      if (b10.tc !== 1'b1 || b10.j_vec !== 4'b0000 || b10.k_vec !== 4'b1001) begin
         bad++; $display("FAIL up_tc: tc=%b j=%b k=%b want 1/0000/1001", b10.tc, b10.j_vec, b10.k_vec);
      end
      tick();
      total++;
      if (b10.q !== 4'd0 || b10.wrap !== 1'b1) begin
         bad++; $display("FAIL up_wrap: q=%0d wrap=%b want q=0 wrap=1", b10.q, b10.wrap);
      end
      drive10(1'b0, 1'b1, 1'b0, 4'd0);
      tick();
      total++;
      if (b10.q !== 4'd0 || b10.wrap !== 1'b0) begin
         bad++; $display("FAIL up_wrap_pulse: q=%0d wrap=%b want q=0 wrap=0", b10.q, b10.wrap);
      end
   endtask

   task automatic test_down_wrap();
      drive10(1'b1, 1'b0, 1'b0, 4'd0);
      #1;
      total++;
      if (b10.tc !== 1'b1 || b10.j_vec !== 4'b1001 || b10.k_vec !== 4'b0000) begin
         bad++; $display("FAIL down_tc: tc=%b j=%b k=%b want 1/1001/0000", b10.tc, b10.j_vec, b10.k_vec);
      end
      tick();
      total++;
      if (b10.q !== 4'd9 || b10.wrap !== 1'b1) begin
         bad++; $display("FAIL down_wrap: q=%0d wrap=%b want q=9 wrap=1", b10.q, b10.wrap);
      end
      drive10(1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      total++;
      if (b10.q !== 4'd9 || b10.wrap !== 1'b0) begin
         bad++; $display("FAIL down_wrap_pulse: q=%0d wrap=%b want q=9 wrap=0", b10.q, b10.wrap);
      end
   endtask

   task automatic test_load();
      logic [3:0] lvs [3] = '{4'd5, 4'd12, 4'd0};
      logic [3:0] exp [3] = '{4'd5, 4'd9, 4'd0};
      for (int i = 0; i < 3; i++) begin
         drive10(1'b1, 1'b1, 1'b1, lvs[i]);
         #1;
         total++;
         if (b10.tc !== 1'b0) begin bad++; $display("FAIL load_tc: tc=%b want 0", b10.tc); end
         tick();
         total++;
         if (b10.q !== exp[i] || b10.wrap !== 1'b0) begin
            bad++; $display("FAIL load_val: q=%0d wrap=%b want q=%0d wrap=0", b10.q, b10.wrap, exp[i]);
         end
      end
   endtask

   task automatic test_direction_flip();
      int qm = 3;
      drive10(1'b0, 1'b1, 1'b1, 4'd3);
      tick();
      for (int i = 0; i < 4; i++) begin
         bit dir = (i % 2 == 0);
         int n = dir ? qm + 1 : qm - 1;
         drive10(1'b1, dir, 1'b0, 4'd0);
         #1;
         total++;
         if (b10.j_vec !== exc_j(qm, n) || b10.k_vec !== exc_k(qm, n)) begin
            bad++; $display("FAIL flip_exc: j=%b k=%b want %b/%b", b10.j_vec, b10.k_vec, exc_j(qm, n), exc_k(qm, n));
         end
         tick();
         qm = n;
         total++;
         if (b10.q !== 4'(qm)) begin bad++; $display("FAIL flip_q: q=%0d want %0d", b10.q, qm); end
      end
      drive10(1'b0, 1'b1, 1'b0, 4'd0);
   endtask

   task automatic test_random();
      int  m10 = 0, m16 = 0, n10, n16;
      bit  w10, w16, en, up, load;
      logic [3:0] lv;
      drive10(1'b0, 1'b1, 1'b1, 4'd0);
      b16.en = 1'b0; b16.up = 1'b1; b16.load = 1'b1; b16.load_val = 4'd0;
      tick();
      for (int c = 0; c < 2000; c++) begin
         en   = ($urandom_range(0, 3) != 0);
         up   = $urandom_range(0, 1) == 1;
         load = ($urandom_range(0, 9) == 0);
         lv   = 4'($urandom_range(0, 15));
         drive10(en, up, load, lv);
         b16.en = en; b16.up = up; b16.load = load; b16.load_val = lv;
         #1;
         n10 = model_nxt(10, m10, en, up, load, int'(lv));
         n16 = model_nxt(16, m16, en, up, load, int'(lv));
         w10 = model_tc(10, m10, en, up, load);
         w16 = model_tc(16, m16, en, up, load);
         total++;
         if (b10.tc !== w10 || b10.j_vec !== exc_j(m10, n10) || b10.k_vec !== exc_k(m10, n10)
             || (b10.j_vec & b10.k_vec) !== 4'd0) begin
            bad++; $display("FAIL rand10_comb: cyc=%0d tc=%b j=%b k=%b want %b/%b/%b", c,
                            b10.tc, b10.j_vec, b10.k_vec, w10, exc_j(m10, n10), exc_k(m10, n10));
         end
         total++;
         if (b16.tc !== w16 || b16.j_vec !== exc_j(m16, n16) || b16.k_vec !== exc_k(m16, n16)
             || (b16.j_vec & b16.k_vec) !== 4'd0) begin
            bad++; $display("FAIL rand16_comb: cyc=%0d tc=%b j=%b k=%b want %b/%b/%b", c,
                            b16.tc, b16.j_vec, b16.k_vec, w16, exc_j(m16, n16), exc_k(m16, n16));
         end
         tick();
         m10 = n10;
         m16 = n16;
         total++;
         if (b10.q !== 4'(m10) || b10.wrap !== w10 || int'(b10.q) >= 10) begin
            bad++; $display("FAIL rand10_q: cyc=%0d q=%0d wrap=%b want q=%0d wrap=%b", c, b10.q, b10.wrap, m10, w10);
         end
         total++;
         if (b16.q !== 4'(m16) || b16.wrap !== w16) begin
            bad++; $display("FAIL rand16_q: cyc=%0d q=%0d wrap=%b want q=%0d wrap=%b", c, b16.q, b16.wrap, m16, w16);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      n_rst = 1'b0;
      drive10(1'b0, 1'b1, 1'b0, 4'd0);
      b16.en = 1'b0; b16.up = 1'b1; b16.load = 1'b0; b16.load_val = 4'd0;
      #12;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load();
      test_direction_flip();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
